program_loader: RTL and testbench

//   Boot-time loader between the UART receiver and program memory. It assembles

---
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles UART bytes (low byte first) into instructions and writes
// them to program memory until HALT. Optional checksum stage: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned       NBITS_O     = 11,
    parameter int unsigned       NBITS_D     = 16,
    parameter int unsigned       NBITS_B     = 8,
    parameter int unsigned       OPCODE      = 5,
    parameter logic [OPCODE-1:0] HALT_OPCODE = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NBITS_B-1:0] i_RxData,
    input  logic               i_RxDone,
    input  logic               i_Clear,
    output logic               o_WrEn,
    output logic [NBITS_O-1:0] o_WrAddr,
    output logic [NBITS_D-1:0] o_WrData,
    output logic               o_CpuReset,
    output logic               o_Loaded,
    output logic               o_Error
);

    localparam logic [2:0] S_LOW   = 3'd0;
    localparam logic [2:0] S_HIGH  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    logic [2:0]         r_state,     w_state_nxt;
    logic [NBITS_O-1:0] r_addr,      w_addr_nxt;
    logic [NBITS_B-1:0] r_lo,        w_lo_nxt;
    logic [NBITS_D-1:0] r_wr_data,   w_wr_data_nxt;
    logic               r_wr_en,     w_wr_en_nxt;
    logic               r_cpu_reset, w_cpu_reset_nxt;
    logic               r_loaded,    w_loaded_nxt;
    logic               r_error,     w_error_nxt;
    logic [OPCODE-1:0]  w_opcode;
`ifdef LOADER_CHECKSUM_EN
    logic [NBITS_B-1:0] r_xor,       w_xor_nxt;
`endif

    assign w_opcode = r_wr_data[NBITS_D-1 -: OPCODE];

    // Next-state and next-register values; i_Clear overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_lo_nxt      = r_lo;
        w_wr_data_nxt = r_wr_data;
        w_wr_en_nxt   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_xor_nxt     = r_xor;
`endif
        if (i_Clear) begin
            w_state_nxt = S_LOW;
            w_addr_nxt  = '0;
            w_lo_nxt    = '0;
`ifdef LOADER_CHECKSUM_EN
            w_xor_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_LOW: begin
                    if (i_RxDone) begin
                        w_lo_nxt    = i_RxData;
                        w_state_nxt = S_HIGH;
`ifdef LOADER_CHECKSUM_EN
                        w_xor_nxt   = r_xor ^ i_RxData;
`endif
                    end
                end
                S_HIGH: begin
                    if (i_RxDone) begin
                        w_wr_data_nxt = NBITS_D'({i_RxData, r_lo});
                        w_wr_en_nxt   = 1'b1;
                        w_state_nxt   = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                        w_xor_nxt     = r_xor ^ i_RxData;
`endif
                    end
                end
                S_WRITE: begin
                    if (w_opcode == HALT_OPCODE) begin
`ifdef LOADER_CHECKSUM_EN
                        // A checksum byte arriving right away is judged here
                        if (i_RxDone)
                            w_state_nxt = (i_RxData == r_xor) ? S_DONE : S_ERROR;
                        else
                            w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else if (r_addr == '1) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_addr_nxt = r_addr + NBITS_O'(1);
                        if (i_RxDone) begin
                            w_lo_nxt    = i_RxData;
                            w_state_nxt = S_HIGH;
`ifdef LOADER_CHECKSUM_EN
                            w_xor_nxt   = r_xor ^ i_RxData;
`endif
                        end else begin
                            w_state_nxt = S_LOW;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (i_RxDone)
                        w_state_nxt = (i_RxData == r_xor) ? S_DONE : S_ERROR;
                end
`endif
                S_DONE:  w_state_nxt = S_DONE;
                S_ERROR: w_state_nxt = S_ERROR;
                default: w_state_nxt = S_LOW;
            endcase
        end
        w_cpu_reset_nxt = (w_state_nxt != S_DONE);
        w_loaded_nxt    = (w_state_nxt == S_DONE);
        w_error_nxt     = (w_state_nxt == S_ERROR);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_LOW;
            r_addr      <= '0;
            r_lo        <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
            r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_lo        <= w_lo_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_loaded    <= w_loaded_nxt;
            r_error     <= w_error_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= w_xor_nxt;
`endif
        end
    end

    assign o_WrEn     = r_wr_en;
    assign o_WrAddr   = r_addr;
    assign o_WrData   = r_wr_data;
    assign o_CpuReset = r_cpu_reset;
    assign o_Loaded   = r_loaded;
    assign o_Error    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized byte
// streams checked against a byte-stream reference model.
module tb_program_loader;

    typedef logic [7:0] byte_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_RxData;
    logic        i_RxDone;
    logic        i_Clear;
    logic        o_WrEn;
    logic [10:0] o_WrAddr;
    logic [15:0] o_WrData;
    logic        o_CpuReset;
    logic        o_Loaded;
    logic        o_Error;

    int n_tests = 0;
    int n_fail  = 0;

    byte_t       seq[$];
    logic [26:0] exp_q[$];
    logic [26:0] obs_q[$];
    logic        exp_loaded;
    logic        exp_error;

    program_loader dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_RxData   (i_RxData),
        .i_RxDone   (i_RxDone),
        .i_Clear    (i_Clear),
        .o_WrEn     (o_WrEn),
        .o_WrAddr   (o_WrAddr),
        .o_WrData   (o_WrData),
        .o_CpuReset (o_CpuReset),
        .o_Loaded   (o_Loaded),
        .o_Error    (o_Error)
    );

    always #5 clk = ~clk;

    // Record every memory write as {addr, data}
    always @(negedge clk) begin
        if (o_WrEn === 1'b1) obs_q.push_back({o_WrAddr, o_WrData});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: walk the byte stream as 16-bit words, stopping at HALT or overflow
    task automatic model();
        int    addr = 0;
        int    i = 0;
        bit    stop = 0;
        byte_t x = 8'h00;
        logic [15:0] word;
        exp_q.delete();
        exp_loaded = 1'b0;
        exp_error  = 1'b0;
        while (!stop && (i + 1 < seq.size())) begin
            word = {seq[i+1], seq[i]};
            x = x ^ seq[i] ^ seq[i+1];
            i += 2;
            exp_q.push_back({11'(addr), word});
            if (word[15:11] == 5'd0) begin
                stop = 1;
`ifdef LOADER_CHECKSUM_EN
                if (i < seq.size()) begin
                    if (seq[i] == x) exp_loaded = 1'b1;
                    else             exp_error  = 1'b1;
                end
`else
                exp_loaded = 1'b1;
`endif
            end else if (addr == 2047) begin
                stop = 1;
                exp_error = 1'b1;
            end else begin
                addr++;
            end
        end
    endtask

    // Caller is at a negedge; leaves the bench at a negedge
    task automatic send_byte(input byte_t b, input int gap);
        i_RxData = b;
        i_RxDone = 1'b1;
        @(negedge clk);
        i_RxDone = 1'b0;
        i_RxData = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input int maxgap);
        foreach (seq[k]) send_byte(seq[k], int'($urandom_range(maxgap, 0)));
    endtask

    task automatic do_clear();
        i_Clear = 1'b1;
        @(negedge clk);
        i_Clear = 1'b0;
        @(negedge clk);
        obs_q.delete();
    endtask

    task automatic check_run(input string tag);
        int n;
        repeat (4) @(negedge clk);
        chk({tag, ".nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, ".loaded"},   32'(o_Loaded),   32'(exp_loaded));
        chk({tag, ".error"},    32'(o_Error),    32'(exp_error));
        chk({tag, ".cpureset"}, 32'(o_CpuReset), 32'(!exp_loaded));
    endtask

    initial begin
        i_reset  = 1'b1;
        i_RxData = 8'h00;
        i_RxDone = 1'b0;
        i_Clear  = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst.wren",     32'(o_WrEn),     32'd0);
        chk("rst.wraddr",   32'(o_WrAddr),   32'd0);
        chk("rst.wrdata",   32'(o_WrData),   32'd0);
        chk("rst.cpureset", 32'(o_CpuReset), 32'd1);
        chk("rst.loaded",   32'(o_Loaded),   32'd0);
        chk("rst.error",    32'(o_Error),    32'd0);

        // Basic two-word program ending in HALT
        obs_q.delete();
        seq = '{8'h01, 8'h08, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h09);
`endif
        model();
        send_seq(2);
        check_run("basic");

        // Clear out of the loaded state, then a partial program
        i_Clear = 1'b1;
        @(negedge clk);
        i_Clear = 1'b0;
        chk("clr.loaded",   32'(o_Loaded),   32'd0);
        chk("clr.cpureset", 32'(o_CpuReset), 32'd1);
        @(negedge clk);
        obs_q.delete();
        seq = '{8'h34, 8'h12};
        model();
        send_seq(1);
        check_run("after_clear");

        // Fill all 2048 addresses without HALT, extra bytes must be ignored
        do_clear();
        seq.delete();
        for (int k = 0; k < 4098; k++) seq.push_back(8'hFF);
        model();
        send_seq(0);
        check_run("overflow");

        // Asynchronous reset with a half-assembled word pending
        do_clear();
        send_byte(8'h55, 1);
        #1 i_reset = 1'b1;
        #1;
        chk("arst.cpureset", 32'(o_CpuReset), 32'd1);
        chk("arst.wren",     32'(o_WrEn),     32'd0);
        chk("arst.error",    32'(o_Error),    32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        seq = '{8'h34, 8'h12, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h26);
`endif
        model();
        send_seq(2);
        check_run("mid_reset");

        // Clear and high byte in the same cycle: no write, restart at address 0
        do_clear();
        send_byte(8'h34, 1);
        i_RxData = 8'h12;
        i_RxDone = 1'b1;
        i_Clear  = 1'b1;
        @(negedge clk);
        i_RxDone = 1'b0;
        i_Clear  = 1'b0;
        @(negedge clk);
        seq = '{8'h78, 8'h56, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h2E);
`endif
        model();
        send_seq(1);
        check_run("clear_vs_rx");

`ifdef LOADER_CHECKSUM_EN
        do_clear();
        seq = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h09};
        model();
        send_seq(1);
        check_run("csum_ok");
        do_clear();
        seq = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h0A};
        model();
        send_seq(1);
        check_run("csum_bad");
`endif

        // Randomized programs: variable length, spacing, with/without HALT
        for (int r = 0; r < 10; r++) begin
            int    nw;
            int    mode;
            byte_t x;
            seq.delete();
            nw   = int'($urandom_range(20, 1));
            mode = int'($urandom_range(3, 0));
            for (int k = 0; k < nw; k++) begin
                seq.push_back(8'($urandom));
                seq.push_back(8'($urandom_range(255, 8)));
            end
            if (mode != 0) begin
                seq.push_back(8'($urandom));
                seq.push_back(8'($urandom_range(7, 0)));
                x = 8'h00;
                foreach (seq[k]) x = x ^ seq[k];
`ifdef LOADER_CHECKSUM_EN
                seq.push_back((mode == 1) ? x : 8'($urandom));
`endif
            end
            for (int k = 0; k < int'($urandom_range(3, 0)); k++) seq.push_back(8'($urandom));
            do_clear();
            model();
            send_seq(int'($urandom_range(3, 0)));
            check_run($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
